// File: rtl/mem_wb_pipe.sv
// ============================================================================
// Module  : mem_wb_pipe
// Brief   : MEM->WB pipeline register, 1..4 stages, with stall/flush,
//           write-back select, RF write qualify and retire counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] DRAM_rd,
  input  logic [DATA_W-1:0] mem_pc4,
  input  logic [DATA_W-1:0] mem_imm,
  input  logic [1:0]        mem_wD_sel,
  input  logic              mem_RF_WE,
  input  logic [INST_W-1:0] mem_inst,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [INST_W-1:0] wb_inst,
  output logic [4:0]        wb_rd,
  output logic              wb_RF_WE,
  output logic [DATA_W-1:0] wb_wD,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [1:0] c_SEL_ALU  = 2'b00;
  localparam logic [1:0] c_SEL_DRAM = 2'b01;
  localparam logic [1:0] c_SEL_PC4  = 2'b10;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("mem_wb_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  logic              valid_q [DEPTH];
  logic [DATA_W-1:0] alu_q   [DEPTH];
  logic [DATA_W-1:0] dram_q  [DEPTH];
  logic [DATA_W-1:0] pc4_q   [DEPTH];
  logic [DATA_W-1:0] imm_q   [DEPTH];
  logic [1:0]        sel_q   [DEPTH];
  logic              we_q    [DEPTH];
  logic [INST_W-1:0] inst_q  [DEPTH];

  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;
  logic              w_pred_valid;
  logic              w_final_load;

  // Flush only clears valid; data fields hold, which is invisible since
  // wb_RF_WE is gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        alu_q[k]   <= '0;
        dram_q[k]  <= '0;
        pc4_q[k]   <= '0;
        imm_q[k]   <= '0;
        sel_q[k]   <= '0;
        we_q[k]    <= 1'b0;
        inst_q[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= mem_valid;
      alu_q[0]   <= mem_alu_result;
      dram_q[0]  <= DRAM_rd;
      pc4_q[0]   <= mem_pc4;
      imm_q[0]   <= mem_imm;
      sel_q[0]   <= mem_wD_sel;
      we_q[0]    <= mem_RF_WE;
      inst_q[0]  <= mem_inst;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        alu_q[k]   <= alu_q[k-1];
        dram_q[k]  <= dram_q[k-1];
        pc4_q[k]   <= pc4_q[k-1];
        imm_q[k]   <= imm_q[k-1];
        sel_q[k]   <= sel_q[k-1];
        we_q[k]    <= we_q[k-1];
        inst_q[k]  <= inst_q[k-1];
      end
    end
  end

  generate
    if (DEPTH == 1) begin : g_pred_in
      assign w_pred_valid = mem_valid;
    end else begin : g_pred_stage
      assign w_pred_valid = valid_q[DEPTH-2];
    end
  endgenerate

  always_comb begin
    w_final_load = 1'b0;
    if (!flush && !stall) begin
      w_final_load = w_pred_valid;
    end
    retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, w_final_load};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    wb_wD = imm_q[DEPTH-1];
    case (sel_q[DEPTH-1])
      c_SEL_ALU:  wb_wD = alu_q[DEPTH-1];
      c_SEL_DRAM: wb_wD = dram_q[DEPTH-1];
      c_SEL_PC4:  wb_wD = pc4_q[DEPTH-1];
      default:    wb_wD = imm_q[DEPTH-1];
    endcase
  end

  assign wb_valid   = valid_q[DEPTH-1];
  assign wb_inst    = inst_q[DEPTH-1];
  assign wb_rd      = inst_q[DEPTH-1][11:7];
  assign wb_RF_WE   = valid_q[DEPTH-1] & we_q[DEPTH-1] & (inst_q[DEPTH-1][11:7] != 5'd0);
  assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire
